// File: rtl/brick_wall_ctrl_if.sv
// Game-side bus of the brick wall controller: player/collision inputs and
// the registered game status returned to the display and ball logic.
interface brick_wall_ctrl_if;
  logic        start;
  logic [24:0] hit;
  logic        ball_lost;
  logic [24:0] collision_ball;
  logic [9:0]  score;
  logic [1:0]  lives;
  logic [1:0]  state;
  logic        ball_enable;

  modport master (
    output start, hit, ball_lost,
    input  collision_ball, score, lives, state, ball_enable
  );

  modport slave (
    input  start, hit, ball_lost,
    output collision_ball, score, lives, state, ball_enable
  );
endinterface

// File: rtl/brick_wall_ctrl.sv
// Brick wall game controller: tracks destroyed blocks/rocks, score and lives,
// and sequences the IDLE/PLAY/CLEARED/OVER game flow.
module brick_wall_ctrl #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned BLOCK_PTS  = 1,
  parameter int unsigned ROCK_PTS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  brick_wall_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_CLEARED = 2'd2;
  localparam logic [1:0] S_OVER    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [24:0] mask_q, mask_d;
  logic [4:0]  cracked_q, cracked_d;
  logic [9:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        ball_en_q;
  logic [24:0] hit_prev;
  logic        start_prev;

  logic        start_edge;
  logic [24:0] strike;
  logic [19:0] block_kill;
  logic [4:0]  rock_kill;
  int unsigned n_blocks, n_rocks, gain, sum;

  always_comb begin
    start_edge = bus.start & ~start_prev;
    strike     = bus.hit & ~hit_prev & ~mask_q;
    block_kill = strike[19:0];
    rock_kill  = strike[24:20] & cracked_q;

    n_blocks = 0;
    n_rocks  = 0;
    for (int unsigned i = 0; i < 20; i++) n_blocks += 32'(block_kill[i]);
    for (int unsigned i = 0; i < 5; i++)  n_rocks  += 32'(rock_kill[i]);
    gain = BLOCK_PTS * n_blocks + ROCK_PTS * n_rocks;
    sum  = 32'(score_q) + gain;

    state_d   = state_q;
    mask_d    = mask_q;
    cracked_d = cracked_q;
    score_d   = score_q;
    lives_d   = lives_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_PLAY;
          mask_d    = '0;
          cracked_d = '0;
          score_d   = '0;
          lives_d   = 2'(LIVES_INIT);
        end
      end
      S_PLAY: begin
        mask_d    = mask_q | {rock_kill, block_kill};
        cracked_d = cracked_q | strike[24:20];
        score_d   = (sum > 32'd1023) ? '1 : sum[9:0];
        // Clearing the wall takes priority over a simultaneous ball loss
        if (mask_d == '1) begin
          state_d = S_CLEARED;
        end else if (bus.ball_lost) begin
          if (lives_q <= 2'd1) begin
            state_d = S_OVER;
            lives_d = '0;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end
      end
      S_CLEARED: begin
        if (start_edge) begin
          state_d   = S_PLAY;
          mask_d    = '0;
          cracked_d = '0;
        end
      end
      S_OVER: begin
        if (start_edge) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      cracked_q  <= '0;
      score_q    <= '0;
      lives_q    <= 2'(LIVES_INIT);
      ball_en_q  <= 1'b0;
      hit_prev   <= '0;
      // Track start during reset so a button held through release is not an edge
      start_prev <= bus.start;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cracked_q  <= cracked_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      ball_en_q  <= (state_d == S_PLAY);
      hit_prev   <= bus.hit;
      start_prev <= bus.start;
    end
  end

  assign bus.collision_ball = mask_q;
  assign bus.score          = score_q;
  assign bus.lives          = lives_q;
  assign bus.state          = state_q;
  assign bus.ball_enable    = ball_en_q;

endmodule

// File: tb/tb_brick_wall_ctrl.sv
// Bench for brick_wall_ctrl: vector table plus hand-built game sequences,
// expectations queued at drive time and checked one cycle later.
module tb_brick_wall_ctrl;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PLAY    = 2'd1;
  localparam logic [1:0] CLEARED = 2'd2;
  localparam logic [1:0] OVER    = 2'd3;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic [24:0] hit;
    logic        ball_lost;
    logic [24:0] mask;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic [1:0]  st;
    logic        en;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tv[$];

  brick_wall_ctrl_if bus ();

  brick_wall_ctrl #(.LIVES_INIT(3), .BLOCK_PTS(1), .ROCK_PTS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic r, logic s, logic [24:0] h, logic bl,
                              logic [24:0] m, logic [9:0] sc, logic [1:0] lv, logic [1:0] st);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.hit = h; v.ball_lost = bl;
    v.mask = m; v.score = sc; v.lives = lv; v.st = st; v.en = (st == PLAY);
    return v;
  endfunction

  function automatic logic [9:0] sat(int unsigned x);
    return (x > 1023) ? 10'd1023 : 10'(x);
  endfunction

  task automatic chk(string n, string f, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    rst           = v.rst;
    bus.start     = v.start;
    bus.hit       = v.hit;
    bus.ball_lost = v.ball_lost;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, "mask",  32'(bus.collision_ball), 32'(e.mask));
    chk(e.name, "score", 32'(bus.score),          32'(e.score));
    chk(e.name, "lives", 32'(bus.lives),          32'(e.lives));
    chk(e.name, "state", 32'(bus.state),          32'(e.st));
    chk(e.name, "en",    32'(bus.ball_enable),    32'(e.en));
  endtask

  initial begin
    logic [9:0] s;

    bus.start = 1'b1; bus.hit = '0; bus.ball_lost = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, start held through release, first game and strikes
    tv.push_back(mk("rst_hold",     0, 1, 25'h0,       0, 25'h0,       0, 3, IDLE));
    tv.push_back(mk("rel_start_hi", 1, 1, 25'h0,       0, 25'h0,       0, 3, IDLE));
    tv.push_back(mk("start_low",    1, 0, 25'h0,       0, 25'h0,       0, 3, IDLE));
    tv.push_back(mk("start_edge",   1, 1, 25'h0,       0, 25'h0,       0, 3, PLAY));
    tv.push_back(mk("start_rel",    1, 0, 25'h0,       0, 25'h0,       0, 3, PLAY));
    tv.push_back(mk("hit0",         1, 0, 25'h0000001, 0, 25'h0000001, 1, 3, PLAY));
    tv.push_back(mk("gap1",         1, 0, 25'h0,       0, 25'h0000001, 1, 3, PLAY));
    tv.push_back(mk("rock20_a",     1, 0, 25'h0100000, 0, 25'h0000001, 1, 3, PLAY));
    tv.push_back(mk("gap2",         1, 0, 25'h0,       0, 25'h0000001, 1, 3, PLAY));
    tv.push_back(mk("rock20_b",     1, 0, 25'h0100000, 0, 25'h0100001, 4, 3, PLAY));
    tv.push_back(mk("gap3",         1, 0, 25'h0,       0, 25'h0100001, 4, 3, PLAY));
    tv.push_back(mk("rock21_crack", 1, 0, 25'h0200000, 0, 25'h0100001, 4, 3, PLAY));
    tv.push_back(mk("gap4",         1, 0, 25'h0,       0, 25'h0100001, 4, 3, PLAY));
    tv.push_back(mk("multi",        1, 0, 25'h0200023, 0, 25'h0300023, 9, 3, PLAY));
    tv.push_back(mk("gap5",         1, 0, 25'h0,       0, 25'h0300023, 9, 3, PLAY));
    for (int i = 0; i < 10; i++)
      tv.push_back(mk("hold3",      1, 0, 25'h0000008, 0, 25'h030002B, 10, 3, PLAY));
    tv.push_back(mk("gap6",         1, 0, 25'h0,       0, 25'h030002B, 10, 3, PLAY));
    tv.push_back(mk("lost1",        1, 0, 25'h0,       1, 25'h030002B, 10, 2, PLAY));

    foreach (tv[i]) apply(tv[i]);

    // Finish the wall: last rock together with ball_lost
    apply(mk("wall_a",      1, 0, 25'h1CFFFD4, 0, 25'h03FFFFF, 26, 2, PLAY));
    apply(mk("gap7",        1, 0, 25'h0,       0, 25'h03FFFFF, 26, 2, PLAY));
    apply(mk("wall_b",      1, 0, 25'h0C00000, 0, 25'h0FFFFFF, 32, 2, PLAY));
    apply(mk("gap8",        1, 0, 25'h0,       0, 25'h0FFFFFF, 32, 2, PLAY));
    apply(mk("last_lost",   1, 0, 25'h1000000, 1, 25'h1FFFFFF, 35, 2, CLEARED));
    apply(mk("clr_lost",    1, 0, 25'h0,       1, 25'h1FFFFFF, 35, 2, CLEARED));
    apply(mk("clr_hit",     1, 0, 25'h0000001, 0, 25'h1FFFFFF, 35, 2, CLEARED));
    apply(mk("resume",      1, 1, 25'h0,       0, 25'h0,       35, 2, PLAY));
    apply(mk("resume_rel",  1, 0, 25'h0,       0, 25'h0,       35, 2, PLAY));

    // Repeated walls drive the score into saturation
    s = 10'd35;
    for (int w = 0; w < 31; w++) begin
      s = sat(32'(s) + 20);
      apply(mk("sat_blocks", 1, 0, 25'h1FFFFFF, 0, 25'h00FFFFF, s, 2, PLAY));
      apply(mk("sat_gap",    1, 0, 25'h0,       0, 25'h00FFFFF, s, 2, PLAY));
      s = sat(32'(s) + 15);
      apply(mk("sat_rocks",  1, 0, 25'h1F00000, 0, 25'h1FFFFFF, s, 2, CLEARED));
      apply(mk("sat_resume", 1, 1, 25'h0,       0, 25'h0,       s, 2, PLAY));
      apply(mk("sat_rel",    1, 0, 25'h0,       0, 25'h0,       s, 2, PLAY));
    end

    // Game over, ignored inputs, back to IDLE and a fresh game
    apply(mk("lost_a",      1, 0, 25'h0,       1, 25'h0, 1023, 1, PLAY));
    apply(mk("lost_b",      1, 0, 25'h0,       1, 25'h0, 1023, 0, OVER));
    apply(mk("over_hit",    1, 0, 25'h0000001, 0, 25'h0, 1023, 0, OVER));
    apply(mk("over_lost",   1, 0, 25'h0,       1, 25'h0, 1023, 0, OVER));
    apply(mk("to_idle",     1, 1, 25'h0,       0, 25'h0, 1023, 0, IDLE));
    apply(mk("idle_rel",    1, 0, 25'h0,       0, 25'h0, 1023, 0, IDLE));
    apply(mk("idle_hit",    1, 0, 25'h0000004, 1, 25'h0, 1023, 0, IDLE));
    apply(mk("new_game",    1, 1, 25'h0,       0, 25'h0, 0,    3, PLAY));
    apply(mk("ng_rel",      1, 0, 25'h0,       0, 25'h0, 0,    3, PLAY));
    apply(mk("three_a",     1, 0, 25'h0,       1, 25'h0, 0,    2, PLAY));
    apply(mk("three_gap",   1, 0, 25'h0,       0, 25'h0, 0,    2, PLAY));
    apply(mk("three_b",     1, 0, 25'h0,       1, 25'h0, 0,    1, PLAY));
    apply(mk("three_gap2",  1, 0, 25'h0,       0, 25'h0, 0,    1, PLAY));
    apply(mk("three_c",     1, 0, 25'h0,       1, 25'h0, 0,    0, OVER));
    apply(mk("over_hit9",   1, 0, 25'h0000200, 0, 25'h0, 0,    0, OVER));
    apply(mk("over_idle",   1, 1, 25'h0,       0, 25'h0, 0,    0, IDLE));
    apply(mk("oi_rel",      1, 0, 25'h0,       0, 25'h0, 0,    0, IDLE));

    // Reset mid-game discards the strike of that cycle
    apply(mk("g3_start",    1, 1, 25'h0,       0, 25'h0,       0, 3, PLAY));
    apply(mk("g3_hit4",     1, 0, 25'h0000010, 0, 25'h0000010, 1, 3, PLAY));
    apply(mk("g3_gap",      1, 0, 25'h0,       0, 25'h0000010, 1, 3, PLAY));
    apply(mk("rst_mid",     0, 0, 25'h0000080, 0, 25'h0,       0, 3, IDLE));
    apply(mk("post_rst",    1, 0, 25'h0,       0, 25'h0,       0, 3, IDLE));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
